regfile_wb_scheduler: RTL

Sequences Y86-64 write-back into the single-write-port register file.
- Accepts one retiring instruction per handshake and decodes dstE/dstM from icode, cnd, rA and rB.
- Serialises the E and M writes onto the one port.
- Shares the same port with a debug/loader write requester.
- Sits between the memory/write-back stage and the register file.

---
 rtl/y86_pkg.sv | 27 ++
 rtl/y86_dst_decode.sv | 32 +++
 rtl/regfile_wb_scheduler.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and write-back scheduler state encoding.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_E = 2'd1,
    WR_M = 2'd2,
    FIN  = 2'd3
  } wb_state_t;

endpackage

// File: rtl/y86_dst_decode.sv
// Combinational dstE/dstM decode from icode, cnd, rA and rB.
module y86_dst_decode
  import y86_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic [3:0]        icode_i,
  input  logic              cnd_i,
  input  logic [ADDR_W-1:0] ra_i,
  input  logic [ADDR_W-1:0] rb_i,
  output logic [ADDR_W-1:0] dst_e_o,
  output logic [ADDR_W-1:0] dst_m_o
);

  localparam logic [ADDR_W-1:0] NONE = ADDR_W'(RNONE);
  localparam logic [ADDR_W-1:0] RSP  = ADDR_W'(RRSP);

  always_comb begin
    dst_e_o = NONE;
    dst_m_o = NONE;
    case (icode_i)
      IIRMOVQ, IOPQ:              dst_e_o = rb_i;
      IRRMOVQ:                    dst_e_o = cnd_i ? rb_i : NONE;
      ICALL, IRET, IPUSHQ, IPOPQ: dst_e_o = RSP;
      default:                    dst_e_o = NONE;
    endcase
    if (icode_i == IMRMOVQ || icode_i == IPOPQ) begin
      dst_m_o = ra_i;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Serialises Y86-64 E then M write-back onto one register-file write port,
// sharing idle cycles with a debug writer that is forced ahead after a starvation limit.
module regfile_wb_scheduler
  import y86_pkg::*;
#(
  parameter int REG_W            = 64,
  parameter int ADDR_W           = 4,
  parameter int DBG_STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_icode,
  input  logic              in_cnd,
  input  logic [ADDR_W-1:0] in_rA,
  input  logic [ADDR_W-1:0] in_rB,
  input  logic [REG_W-1:0]  in_valE,
  input  logic [REG_W-1:0]  in_valM,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [REG_W-1:0]  dbg_data,
  output logic              dbg_gnt,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [REG_W-1:0]  rf_wdata,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DBG_STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0] NONE  = ADDR_W'(RNONE);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(DBG_STARVE_LIMIT);

  wb_state_t         state_q, state_d;
  logic [ADDR_W-1:0] dst_e_q, dst_m_q;
  logic [ADDR_W-1:0] dec_e, dec_m;
  logic [REG_W-1:0]  val_e_q, val_m_q;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              done_q, done_d;
  logic              idle, forced_dbg, accept;

  y86_dst_decode #(.ADDR_W(ADDR_W)) u_dst_decode (
    .icode_i (in_icode),
    .cnd_i   (in_cnd),
    .ra_i    (in_rA),
    .rb_i    (in_rB),
    .dst_e_o (dec_e),
    .dst_m_o (dec_m)
  );

  assign idle       = (state_q == IDLE);
  assign forced_dbg = dbg_req && (starve_q == LIMIT);
  assign in_ready   = rst_n && idle && !forced_dbg;
  assign accept     = in_valid && in_ready;
  // Debug only owns the port in IDLE, and only when no instruction wins it.
  assign dbg_gnt    = rst_n && idle && dbg_req && (forced_dbg || !in_valid);
  assign busy       = !idle;
  assign done       = rst_n && done_q;

  // done_d is asserted for the state whose cycle completes the instruction.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (dec_e != NONE) begin
            state_d = WR_E;
            done_d  = (dec_m == NONE);
          end else if (dec_m != NONE) begin
            state_d = WR_M;
            done_d  = 1'b1;
          end else begin
            state_d = FIN;
            done_d  = 1'b1;
          end
        end
      end
      WR_E: begin
        if (dst_m_q != NONE) begin
          state_d = WR_M;
          done_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (!dbg_req || dbg_gnt) begin
      starve_d = '0;
    end else if (accept && starve_q != LIMIT) begin
      starve_d = starve_q + 1'b1;
    end else begin
      starve_d = starve_q;
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = dst_e_q;
    rf_wdata = val_e_q;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (dbg_gnt) begin
            rf_we    = (dbg_addr != NONE);
            rf_waddr = dbg_addr;
            rf_wdata = dbg_data;
          end
        end
        WR_E: rf_we = (dst_e_q != NONE);
        WR_M: begin
          rf_we    = (dst_m_q != NONE);
          rf_waddr = dst_m_q;
          rf_wdata = val_m_q;
        end
        default: rf_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      done_q   <= 1'b0;
      dst_e_q  <= NONE;
      dst_m_q  <= NONE;
      val_e_q  <= '0;
      val_m_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      done_q   <= done_d;
      if (accept) begin
        dst_e_q <= dec_e;
        dst_m_q <= dec_m;
        val_e_q <= in_valE;
        val_m_q <= in_valM;
      end
    end
  end

endmodule
